// File: rtl/io_arbiter_if.sv
// io_arbiter_if
//   Bundles the request/acknowledge signals of both IO masters and the
//   single-ported IO bus that feeds io_port.
//   Modports:
//     slave  - arbiter view: takes requests, returns acks/read data, drives
//              the IO bus, samples io_data_read, reports busy.
//     master - environment view: the two requesters plus the io_port side.
//   Signals:
//     mX_req/mX_we/mX_addr[7:0]/mX_wdata[31:0] : master X request
//     mX_ack/mX_rdata[31:0]                    : master X completion
//     io_addr[7:0]/io_en/io_we/io_data_write   : registered IO bus cycle
//     io_data_read[31:0]                       : combinational read data
//     busy                                     : arbiter not idle
interface io_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [7:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [7:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output io_addr, io_en, io_we, io_data_write,
    input  io_data_read,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  io_addr, io_en, io_we, io_data_write,
    output io_data_read,
    input  busy
  );
endinterface

// File: rtl/io_arbiter.sv
// io_arbiter
//   Two-master arbiter/sequencer for the single-ported IO bus feeding
//   io_port. Master 0 is the pipeline memory stage, master 1 the
//   debug/loader port. One request is granted at a time and turned into a
//   single registered IO bus cycle; read data is captured at the end of that
//   cycle and returned with a one-cycle acknowledge.
//   Sequence: IDLE (arbitrate/latch) -> ISSUE (bus cycle) -> ACK (ack pulse).
//   Ports:
//     clk    - system clock, rising edge
//     resetb - synchronous reset, active-high (1 = reset)
//     bus    - io_arbiter_if.slave: master handshakes, IO bus, busy
//   Build option:
//     IO_ARB_ROUND_ROBIN_EN - when defined, ties alternate between masters
//                             (the one not granted last wins); otherwise
//                             master 0 always wins a tie.
module io_arbiter (
  input  logic          clk,
  input  logic          resetb,
  io_arbiter_if.slave   bus
);

`ifdef IO_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t      state;
  logic        gnt_id;    // master owning the transaction in flight
  logic        last_gnt;  // master that completed most recently
  logic        we_q;      // latched direction of the transaction in flight
  logic [31:0] rdata_q;   // last captured read data

  logic        any_req;
  logic        win_id;
  logic        win_we;
  logic [7:0]  win_addr;
  logic [31:0] win_wdata;

  // Winner selection. With a single requester the requester wins; on a tie
  // the round-robin build hands the grant to the master not served last,
  // the fixed-priority build always picks master 0.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    win_id  = 1'b0;
    if (RR_EN && bus.m0_req && bus.m1_req) begin
      win_id = ~last_gnt;
    end else begin
      win_id = ~bus.m0_req;
    end
  end

  always_comb begin
    win_we    = bus.m0_we;
    win_addr  = bus.m0_addr;
    win_wdata = bus.m0_wdata;
    if (win_id) begin
      win_we    = bus.m1_we;
      win_addr  = bus.m1_addr;
      win_wdata = bus.m1_wdata;
    end
  end

  // Single registered FSM. The IO bus strobes are loaded on the IDLE->ISSUE
  // edge so they are high for exactly the ISSUE cycle; io_addr and
  // io_data_write double as the latched request and hold afterwards.
  always_ff @(posedge clk) begin
    if (resetb) begin
      state             <= ST_IDLE;
      gnt_id            <= 1'b0;
      last_gnt          <= 1'b1;
      we_q              <= 1'b0;
      rdata_q           <= '0;
      bus.io_addr       <= '0;
      bus.io_en         <= 1'b0;
      bus.io_we         <= 1'b0;
      bus.io_data_write <= '0;
      bus.m0_ack        <= 1'b0;
      bus.m1_ack        <= 1'b0;
      bus.m0_rdata      <= '0;
      bus.m1_rdata      <= '0;
      bus.busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_id            <= win_id;
            we_q              <= win_we;
            bus.io_addr       <= win_addr;
            bus.io_data_write <= win_wdata;
            bus.io_en         <= 1'b1;
            bus.io_we         <= win_we;
            bus.busy          <= 1'b1;
            state             <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          bus.io_en <= 1'b0;
          bus.io_we <= 1'b0;
          // A write leaves rdata_q untouched, so the acked master then sees
          // the most recent read value rather than bus noise.
          if (!we_q) begin
            rdata_q <= bus.io_data_read;
          end
          if (gnt_id) begin
            bus.m1_ack   <= 1'b1;
            bus.m1_rdata <= we_q ? rdata_q : bus.io_data_read;
          end else begin
            bus.m0_ack   <= 1'b1;
            bus.m0_rdata <= we_q ? rdata_q : bus.io_data_read;
          end
          state <= ST_ACK;
        end

        ST_ACK: begin
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
          last_gnt   <= gnt_id;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          bus.io_en  <= 1'b0;
          bus.io_we  <= 1'b0;
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Registered strobes must track the state register exactly.
  a_io_en_state : assert property (@(posedge clk) disable iff (resetb)
    bus.io_en == (state == ST_ISSUE));
  a_busy_state : assert property (@(posedge clk) disable iff (resetb)
    bus.busy == (state != ST_IDLE));
  a_one_ack : assert property (@(posedge clk) disable iff (resetb)
    !(bus.m0_ack && bus.m1_ack));
  a_we_in_issue : assert property (@(posedge clk) disable iff (resetb)
    bus.io_we |-> bus.io_en);
`endif

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter
//   Directed bench for io_arbiter. io_port is modelled combinationally:
//   address 8'h10 reads 32'hDEADBEEF, any other address A reads
//   32'h12345600 ^ A. Inputs change 1 time unit after the rising edge and
//   outputs are checked at the same point.
module tb_io_arbiter;
  logic clk = 1'b0;
  logic resetb = 1'b1;

  always #5 clk = ~clk;

  io_arbiter_if bus ();

  io_arbiter dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always_comb begin
    if (bus.io_addr == 8'h10) bus.io_data_read = 32'hDEADBEEF;
    else                      bus.io_data_read = 32'h12345600 ^ {24'h0, bus.io_addr};
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp0, exp1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;

    // Reset state
    resetb = 1'b1;
    step();
    step();
    check("rst_busy",     bus.busy, 0);
    check("rst_io_en",    bus.io_en, 0);
    check("rst_io_we",    bus.io_we, 0);
    check("rst_io_addr",  bus.io_addr, 0);
    check("rst_io_wdata", bus.io_data_write, 0);
    check("rst_m0_ack",   bus.m0_ack, 0);
    check("rst_m1_ack",   bus.m1_ack, 0);
    check("rst_m0_rdata", bus.m0_rdata, 0);
    check("rst_m1_rdata", bus.m1_rdata, 0);
    resetb = 1'b0;

    // Master 0 read of 8'h10, no contention
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h10;
    step();
    check("rd0_io_en",   bus.io_en, 1);
    check("rd0_io_we",   bus.io_we, 0);
    check("rd0_io_addr", bus.io_addr, 8'h10);
    check("rd0_busy",    bus.busy, 1);
    check("rd0_ack_c1",  bus.m0_ack, 0);
    step();
    check("rd0_ack",     bus.m0_ack, 1);
    check("rd0_rdata",   bus.m0_rdata, 32'hDEADBEEF);
    check("rd0_m1_ack",  bus.m1_ack, 0);
    check("rd0_io_en_c2", bus.io_en, 0);
    bus.m0_req = 0;
    step();
    check("rd0_ack_off", bus.m0_ack, 0);
    check("rd0_idle",    bus.busy, 0);
    check("rd0_addr_hold", bus.io_addr, 8'h10);

    // Master 1 write: rdata returns the last captured read value
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 8'h14; bus.m1_wdata = 32'h00001234;
    step();
    check("wr1_io_en",   bus.io_en, 1);
    check("wr1_io_we",   bus.io_we, 1);
    check("wr1_io_addr", bus.io_addr, 8'h14);
    check("wr1_io_wdata", bus.io_data_write, 32'h00001234);
    step();
    check("wr1_ack",     bus.m1_ack, 1);
    check("wr1_io_we_off", bus.io_we, 0);
    check("wr1_rdata",   bus.m1_rdata, 32'hDEADBEEF);
    check("wr1_m0_ack",  bus.m0_ack, 0);
    check("wr1_m0_hold", bus.m0_rdata, 32'hDEADBEEF);
    bus.m1_req = 0; bus.m1_we = 0;
    step();
    check("wr1_ack_off", bus.m1_ack, 0);
    check("wr1_wdata_hold", bus.io_data_write, 32'h00001234);

    // Master 0 read of 8'h20
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h20;
    step();
    check("rd20_io_addr", bus.io_addr, 8'h20);
    step();
    check("rd20_ack",   bus.m0_ack, 1);
    check("rd20_rdata", bus.m0_rdata, 32'h12345620);
    bus.m0_req = 0;
    step();

    // Address change during ISSUE is ignored
    bus.m0_req = 1; bus.m0_addr = 8'h10;
    step();
    bus.m0_addr = 8'h18;
    check("chg_io_addr", bus.io_addr, 8'h10);
    step();
    check("chg_ack",     bus.m0_ack, 1);
    check("chg_rdata",   bus.m0_rdata, 32'hDEADBEEF);
    check("chg_addr_hold", bus.io_addr, 8'h10);
    bus.m0_req = 0;
    step();

    // Tie between both masters, starting from reset (last_gnt = 1)
    resetb = 1'b1;
    step();
    resetb = 1'b0;
    check("tie_rst_rdata", bus.m0_rdata, 0);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h24;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 8'h28;
    for (int k = 1; k <= 12; k++) begin
      step();
`ifdef IO_ARB_ROUND_ROBIN_EN
      exp0 = (k == 2) || (k == 8);
      exp1 = (k == 5) || (k == 11);
`else
      exp0 = (k % 3) == 2;
      exp1 = 1'b0;
`endif
      check($sformatf("tie_m0_ack_k%0d", k), bus.m0_ack, exp0);
      check($sformatf("tie_m1_ack_k%0d", k), bus.m1_ack, exp1);
      if (exp0) check($sformatf("tie_m0_rdata_k%0d", k), bus.m0_rdata, 32'h12345624);
      if (exp1) check($sformatf("tie_m1_rdata_k%0d", k), bus.m1_rdata, 32'h12345628);
`ifdef IO_ARB_ROUND_ROBIN_EN
      if (exp0) bus.m0_req = 0;
      if (exp1) bus.m1_req = 0;
      if ((k % 3) == 0) begin
        bus.m0_req = 1;
        bus.m1_req = 1;
      end
`endif
    end
    bus.m0_req = 0; bus.m1_req = 0;
    step();
    check("tie_idle", bus.busy, 0);

    // Reset during the ISSUE cycle of a read
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h10;
    step();
    check("mid_io_en", bus.io_en, 1);
    resetb = 1'b1;
    bus.m0_req = 0;
    step();
    check("mid_busy",   bus.busy, 0);
    check("mid_io_en0", bus.io_en, 0);
    check("mid_ack",    bus.m0_ack, 0);
    check("mid_rdata",  bus.m0_rdata, 0);
    check("mid_m1_ack", bus.m1_ack, 0);
    resetb = 1'b0;
    bus.m0_req = 1; bus.m0_addr = 8'h20;
    step();
    check("post_io_en",   bus.io_en, 1);
    check("post_io_addr", bus.io_addr, 8'h20);
    step();
    check("post_ack",     bus.m0_ack, 1);
    check("post_rdata",   bus.m0_rdata, 32'h12345620);
    bus.m0_req = 0;
    step();
    check("post_ack_off", bus.m0_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
